bht2_update_ctrl: RTL and testbench
===================================

Name: bht2_update_ctrl

Overview:
Controller for a table of 2-bit saturating counters, the branch-history table in the front end. It owns the table and serves 1-cycle lookups. Update requests are sequenced through a single shared 2-bit increment/decrement unit, with saturation derived from that unit's carry/borrow. A sweep FSM initialises or flushes every entry, one entry per cycle.

Parameters:
ENTRIES, 16, number of counter entries; must be a power of 2, at least 2.
IDX_W, 4, index width; equals log2(ENTRIES).
INIT_VAL, 2'b01, counter value written by the sweep (weakly not-taken).

Ports:
clk  in  1  clock; all state changes on the rising edge.
resetn  in  1  asynchronous, active-low reset.
flush_req  in  1  request a full-table sweep to INIT_VAL.
busy  out  1  high while a sweep is in progress.
lkp_valid  in  1  lookup request.
lkp_idx  in  IDX_W  lookup index.
rsp_valid  out  1  lookup response valid, one cycle after lkp_valid.
rsp_cnt  out  2  counter value returned for the lookup.
rsp_taken  out  1  equals rsp_cnt[1].
upd_valid  in  1  update request.
upd_ready  out  1  update can be accepted this cycle.
upd_idx  in  IDX_W  update index.
upd_taken  in  1  1 = increment the counter, 0 = decrement it.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (resetn).
- The table array has no reset. All control state does reset.
- Reset values:
  - state = SWEEP, sweep pointer = 0
  - busy = 1, upd_ready = 0
  - rsp_valid = 0, rsp_cnt = 0, rsp_taken = 0
  - S1 valid = 0
- FSM states: SWEEP, RUN.
  - SWEEP: each cycle, write INIT_VAL to entry[ptr], then ptr++.
  - When ptr == ENTRIES-1 is written, the next state is RUN.
  - A sweep therefore lasts exactly ENTRIES cycles.
  - RUN: flush_req = 1 → SWEEP next cycle with ptr = 0.
  - SWEEP: flush_req = 1 → ptr restarts at 0; the sweep lasts ENTRIES more cycles.
- busy = (state == SWEEP).
- upd_ready = (state == RUN) && !flush_req.
- Update pipeline:
  - An update is accepted when upd_valid && upd_ready. It is captured into register stage S1 (idx, taken).
  - In the following cycle S1 reads entry[idx] and drives the decinc unit with d = entry, dec = !taken.
  - Result: new = c ? d : q. On inc, carry means d was 3, so the counter stays at 3. On dec, borrow means d was 0, so it stays at 0.
  - new is written at the end of the S1 cycle.
  - A new update may be accepted every cycle. An update to the same index in the next cycle reads the already-written value, so no stall is needed.
  - An update accepted in the cycle before flush_req is still written; the sweep then overwrites it.
- Lookup:
  - A lookup at cycle L gives rsp_valid = 1 at L+1.
  - The response reflects every update accepted before cycle L.
  - If S1 is valid in cycle L with S1.idx == lkp_idx, the response returns S1's new value (forwarding).
  - Updates accepted in cycle L itself are not visible.
  - A lookup issued in any SWEEP cycle returns INIT_VAL.
  - rsp_cnt holds its last value when rsp_valid = 0.
- Reset asserted mid-operation: the S1 update is dropped and the sweep restarts from 0.
- Indices are always in range, since ENTRIES is a power of 2.

Decomposition:
- Shared package for the core: the FSM state encoding (SWEEP = 1'b0, RUN = 1'b1), the default INIT_VAL constant, and named counter values SNT = 00, WNT = 01, WT = 10, ST = 11.
- One sub-module instance: common_rtlrom_decinc2, the codebase's 2-bit increment/decrement ROM, used as the single shared S1 arithmetic unit.
- The array, forwarding path and FSM stay in this module.

Test Plan:
1. Release resetn → busy = 1 for exactly 16 cycles and upd_ready = 0 throughout. Then busy = 0 and upd_ready = 1. A lookup of idx 5 returns rsp_cnt = 01, rsp_taken = 0.
2. Three back-to-back taken updates to idx 3 → subsequent lookups give 01→10→11→11 (saturated; carry path). rsp_taken = 1 from the second update on.
3. Three not-taken updates to idx 9 from 01 → 00, 00, 00 (borrow path holds at 0).
4. Cycle T: taken update to idx 7, accepted. Cycle T+1: lookup idx 7 → rsp at T+2 = 10 (forwarded from S1). A lookup of idx 7 issued at T returns 01.
5. After writing several entries, pulse flush_req in RUN → upd_ready drops in the same cycle and busy stays high for 16 cycles. Afterwards every idx 0..15 reads 01. A second flush_req pulse at sweep cycle 8 extends busy to 8 + 16 cycles total.
6. Assert resetn = 0 asynchronously while an update is in S1 and mid-sweep → outputs return to reset values immediately. After release, a full 16-cycle sweep occurs and the dropped update is not visible (idx reads 01).

Source files
------------

// File: rtl/bht2_update_ctrl_pkg.sv
// Shared definitions for the 2-bit branch-history table controller:
// FSM state encoding and named saturating-counter values.
package bht2_update_ctrl_pkg;

    localparam logic ST_SWEEP = 1'b0;
    localparam logic ST_RUN   = 1'b1;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam logic [1:0] INIT_VAL_DEF = WNT;

endpackage

// File: rtl/bht2_update_ctrl_if.sv
// Lookup, update and flush signal bundle of the branch-history table.
// master drives requests, slave (the controller) answers them.
interface bht2_update_ctrl_if #(
    parameter int IDX_W = 4
);
    import bht2_update_ctrl_pkg::*;

    logic             flush_req;
    logic             busy;
    logic             lkp_valid;
    logic [IDX_W-1:0] lkp_idx;
    logic             rsp_valid;
    logic [1:0]       rsp_cnt;
    logic             rsp_taken;
    logic             upd_valid;
    logic             upd_ready;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_taken;

    modport master (
        output flush_req, lkp_valid, lkp_idx,
        output upd_valid, upd_idx, upd_taken,
        input  busy, rsp_valid, rsp_cnt,
        input  rsp_taken, upd_ready
    );

    modport slave (
        input  flush_req, lkp_valid, lkp_idx,
        input  upd_valid, upd_idx, upd_taken,
        output busy, rsp_valid, rsp_cnt,
        output rsp_taken, upd_ready
    );

endinterface

// File: rtl/common_rtlrom_decinc2.sv
// 2-bit increment/decrement ROM; c flags carry (inc of 3)
// or borrow (dec of 0), q is the wrapped result.
module common_rtlrom_decinc2
    import bht2_update_ctrl_pkg::*;
(
    input  logic [1:0] d,
    input  logic       dec,
    output logic [1:0] q,
    output logic       c
);

    always_comb begin
        q = SNT;
        c = 1'b0;
        unique case ({dec, d})
            {1'b0, SNT}: q = WNT;
            {1'b0, WNT}: q = WT;
            {1'b0, WT }: q = ST;
            {1'b0, ST }: begin q = SNT; c = 1'b1; end
            {1'b1, SNT}: begin q = ST;  c = 1'b1; end
            {1'b1, WNT}: q = SNT;
            {1'b1, WT }: q = WNT;
            {1'b1, ST }: q = WT;
        endcase
    end

endmodule

// File: rtl/bht2_update_ctrl.sv
// Branch-history table of 2-bit saturating counters with a
// sweep FSM, one-stage update pipeline and S1 lookup forwarding.
module bht2_update_ctrl
    import bht2_update_ctrl_pkg::*;
#(
    parameter int         ENTRIES  = 16,
    parameter int         IDX_W    = 4,
    parameter logic [1:0] INIT_VAL = INIT_VAL_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    bht2_update_ctrl_if.slave bus
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(ENTRIES - 1);

    logic [1:0] mem [ENTRIES];

    logic             state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             s1_vld_q, s1_vld_d;
    logic [IDX_W-1:0] s1_idx_q, s1_idx_d;
    logic             s1_tkn_q, s1_tkn_d;
    logic             rsp_vld_q, rsp_vld_d;
    logic [1:0]       rsp_cnt_q, rsp_cnt_d;

    logic [1:0] s1_old;
    logic [1:0] s1_q;
    logic       s1_c;
    logic [1:0] s1_new;
    logic       accept;

    assign s1_old = mem[s1_idx_q];

    common_rtlrom_decinc2 u_decinc (
        .d   (s1_old),
        .dec (!s1_tkn_q),
        .q   (s1_q),
        .c   (s1_c)
    );

    // carry/borrow means the counter was already at its limit
    assign s1_new = s1_c ? s1_old : s1_q;

    assign bus.busy      = (state_q == ST_SWEEP);
    assign bus.upd_ready = (state_q == ST_RUN) && !bus.flush_req;
    assign accept        = bus.upd_valid && bus.upd_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == ST_SWEEP) begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == LAST) state_d = ST_RUN;
        end
        if (bus.flush_req) begin
            state_d = ST_SWEEP;
            ptr_d   = '0;
        end
    end

    always_comb begin
        s1_vld_d = accept;
        s1_idx_d = s1_idx_q;
        s1_tkn_d = s1_tkn_q;
        if (accept) begin
            s1_idx_d = bus.upd_idx;
            s1_tkn_d = bus.upd_taken;
        end
    end

    always_comb begin
        rsp_vld_d = bus.lkp_valid;
        rsp_cnt_d = rsp_cnt_q;
        if (bus.lkp_valid) begin
            if (state_q == ST_SWEEP)
                rsp_cnt_d = INIT_VAL;
            else if (s1_vld_q && s1_idx_q == bus.lkp_idx)
                rsp_cnt_d = s1_new;
            else
                rsp_cnt_d = mem[bus.lkp_idx];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_SWEEP;
            ptr_q     <= '0;
            s1_vld_q  <= 1'b0;
            s1_idx_q  <= '0;
            s1_tkn_q  <= 1'b0;
            rsp_vld_q <= 1'b0;
            rsp_cnt_q <= SNT;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            s1_vld_q  <= s1_vld_d;
            s1_idx_q  <= s1_idx_d;
            s1_tkn_q  <= s1_tkn_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_cnt_q <= rsp_cnt_d;
        end
    end

    // sweep write placed last so it wins a same-entry collision
    always_ff @(posedge clk) begin
        if (s1_vld_q) mem[s1_idx_q] <= s1_new;
        if (state_q == ST_SWEEP) mem[ptr_q] <= INIT_VAL;
    end

    assign bus.rsp_valid = rsp_vld_q;
    assign bus.rsp_cnt   = rsp_cnt_q;
    assign bus.rsp_taken = rsp_cnt_q[1];

endmodule

// File: tb/tb_bht2_update_ctrl.sv
// Self-checking bench for bht2_update_ctrl: directed scenarios with
// literal expectations plus randomized traffic against a table model.
module tb_bht2_update_ctrl;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    bht2_update_ctrl_if #(.IDX_W(4)) bus ();

    bht2_update_ctrl #(
        .ENTRIES  (16),
        .IDX_W    (4),
        .INIT_VAL (2'b01)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: table values with every accepted update applied at once;
    // a sweep is a count of remaining busy cycles, and the table reads INIT.
    bit         m_sweep = 1'b1;
    int         m_rem = 16;
    logic [1:0] m_cnt [16];
    bit         m_rv = 1'b0;
    logic [1:0] m_rc = 2'b00;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_sweep <= 1'b1;
            m_rem   <= 16;
            m_rv    <= 1'b0;
            m_rc    <= 2'b00;
            for (int i = 0; i < 16; i++) m_cnt[i] <= 2'b01;
        end else begin
            int v;
            m_rv <= bus.lkp_valid;
            if (bus.lkp_valid)
                m_rc <= m_sweep ? 2'b01 : m_cnt[bus.lkp_idx];
            if (bus.upd_valid && !m_sweep && !bus.flush_req) begin
                v = int'(m_cnt[bus.upd_idx]);
                v = bus.upd_taken ? v + 1 : v - 1;
                if (v > 3) v = 3;
                if (v < 0) v = 0;
                m_cnt[bus.upd_idx] <= 2'(v);
            end
            if (bus.flush_req) begin
                m_sweep <= 1'b1;
                m_rem   <= 16;
                for (int i = 0; i < 16; i++) m_cnt[i] <= 2'b01;
            end else if (m_sweep) begin
                m_rem   <= m_rem - 1;
                m_sweep <= (m_rem != 1);
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", int'(bus.busy), int'(m_sweep));
        chk("upd_ready", int'(bus.upd_ready), int'(!m_sweep && !bus.flush_req));
        chk("rsp_valid", int'(bus.rsp_valid), int'(m_rv));
        chk("rsp_cnt", int'(bus.rsp_cnt), int'(m_rc));
        chk("rsp_taken", int'(bus.rsp_taken), int'(m_rc[1]));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flush_req = 1'b0;
        bus.lkp_valid = 1'b0;
        bus.upd_valid = 1'b0;
    endtask

    task automatic count_busy(output int n, output bit rdy);
        n = 0;
        rdy = 1'b0;
        while (bus.busy && n < 100) begin
            if (bus.upd_ready) rdy = 1'b1;
            n++;
            cyc();
        end
    endtask

    // step i: optional update (i < nupd) plus lookup of idx; e[2i+:2] expected
    task automatic seq(input logic [3:0] idx, input bit tk, input int nupd,
                       input int nst, input logic [7:0] e, input string nm);
        for (int i = 0; i < nst; i++) begin
            bus.upd_valid = (i < nupd);
            bus.upd_idx   = idx;
            bus.upd_taken = tk;
            bus.lkp_valid = 1'b1;
            bus.lkp_idx   = idx;
            cyc();
            idle();
            chk(nm, int'(bus.rsp_cnt), int'(e[2*i +: 2]));
            chk({nm, "_tk"}, int'(bus.rsp_taken), int'(e[2*i+1]));
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_busy"}, int'(bus.busy), 1);
        chk({nm, "_rdy"}, int'(bus.upd_ready), 0);
        chk({nm, "_rv"}, int'(bus.rsp_valid), 0);
        chk({nm, "_rc"}, int'(bus.rsp_cnt), 0);
    endtask

    initial begin
        int n;
        bit rdy;
        idle();
        bus.lkp_idx   = '0;
        bus.upd_idx   = '0;
        bus.upd_taken = 1'b0;
        repeat (3) cyc();
        chk_reset_vals("por");
        resetn = 1'b1;

        count_busy(n, rdy);
        chk("init_sweep_len", n, 16);
        chk("init_sweep_rdy", int'(rdy), 0);
        chk("run_rdy", int'(bus.upd_ready), 1);
        seq(4'd5, 1'b0, 0, 1, 8'b00_00_00_01, "lkp5");

        seq(4'd3, 1'b1, 3, 4, 8'b11_11_10_01, "inc3");
        seq(4'd9, 1'b0, 3, 4, 8'b00_00_00_01, "dec9");
        seq(4'd7, 1'b1, 1, 2, 8'b00_00_10_01, "fwd7");

        bus.flush_req = 1'b1;
        #1;
        chk("flush_rdy_drop", int'(bus.upd_ready), 0);
        cyc();
        idle();
        count_busy(n, rdy);
        chk("flush_len", n, 16);
        for (int i = 0; i < 16; i++)
            seq(4'(i), 1'b0, 0, 1, 8'h01, "post_flush");

        bus.flush_req = 1'b1;
        cyc();
        n = 0;
        while (bus.busy && n < 100) begin
            bus.flush_req = (n == 7);
            n++;
            cyc();
        end
        idle();
        chk("reflush_len", n, 24);

        bus.upd_valid = 1'b1;
        bus.upd_idx   = 4'd2;
        bus.upd_taken = 1'b1;
        cyc();
        idle();
        #2;
        resetn = 1'b0;
        #1;
        chk_reset_vals("rst_s1");
        cyc();
        resetn = 1'b1;
        count_busy(n, rdy);
        chk("rst_s1_len", n, 16);

        repeat (5) cyc();
        seq(4'd2, 1'b1, 1, 1, 8'h01, "pre_rst_upd");
        bus.flush_req = 1'b1;
        cyc();
        idle();
        repeat (5) cyc();
        #3;
        resetn = 1'b0;
        #1;
        chk_reset_vals("rst_sweep");
        cyc();
        resetn = 1'b1;
        count_busy(n, rdy);
        chk("rst_sweep_len", n, 16);
        seq(4'd2, 1'b0, 0, 1, 8'h01, "dropped_upd");

        for (int c = 0; c < 3000; c++) begin
            bus.flush_req = ($urandom_range(0, 79) == 0);
            bus.upd_valid = $urandom_range(0, 1) == 1;
            bus.upd_taken = $urandom_range(0, 2) != 0;
            bus.upd_idx   = ($urandom_range(0, 1) == 1)
                          ? 4'($urandom_range(0, 3))
                          : 4'($urandom_range(0, 15));
            bus.lkp_valid = $urandom_range(0, 2) != 0;
            bus.lkp_idx   = ($urandom_range(0, 1) == 1)
                          ? 4'($urandom_range(0, 3))
                          : 4'($urandom_range(0, 15));
            if (c >= 1500 && c < 1800) bus.upd_taken = 1'b0;
            cyc();
        end
        idle();
        repeat (3) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
